// File: rtl/dac_setpt_ramp_engine_if.sv
// -----------------------------------------------------------------------------
// dac_setpt_ramp_engine_if
// Ramp-table write bus between the register bank (master) and the setpoint
// ramp engine (slave).
//   ramp_wr_en    write strobe, one entry per asserted cycle
//   ramp_wr_addr  table entry address
//   ramp_wr_data  signed table entry
// -----------------------------------------------------------------------------
interface dac_setpt_ramp_engine_if #(
  parameter int DAC_WIDTH = 20,
  parameter int AW        = 10
);
  logic                        ramp_wr_en;
  logic [AW-1:0]               ramp_wr_addr;
  logic signed [DAC_WIDTH-1:0] ramp_wr_data;

  modport master (output ramp_wr_en, output ramp_wr_addr, output ramp_wr_data);
  modport slave  (input  ramp_wr_en, input  ramp_wr_addr, input  ramp_wr_data);
endinterface

// File: rtl/dac_setpt_ramp_engine.sv
// -----------------------------------------------------------------------------
// dac_setpt_ramp_engine
// Per-channel DAC setpoint generator: jump, slew-limited smooth, one-shot ramp
// and looping ramp playback from a dual-port table.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   tick          DAC update strobe (1-cycle, >=3 clk apart)
//   opmode        0 smooth, 1 ramp once, 2 ramp loop, 3 jump
//   setpt         signed target setpoint
//   slew_rate     unsigned max |step| per tick in smooth mode
//   ramplen       number of table entries to play (clamped to RAMP_DEPTH)
//   tbl           ramp-table write bus (slave side)
//   ramp_run      start pulse; trig rising edge also starts
//   ramp_abort    abort pulse
//   dac_out       signed setpoint to the serialiser
//   dac_valid     1-cycle pulse, dac_out updated (2 clk after tick)
//   ramp_active   high while a ramp is playing
//   ramp_done     1-cycle pulse with the last entry of a one-shot ramp
//   ramp_idx      table index of the last ramp entry output
// -----------------------------------------------------------------------------
module dac_setpt_ramp_engine #(
  parameter int  DAC_WIDTH  = 20,
  parameter int  RAMP_DEPTH = 1024,
  localparam int AW         = $clog2(RAMP_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [1:0]                  opmode,
  input  logic signed [DAC_WIDTH-1:0] setpt,
  input  logic [DAC_WIDTH-2:0]        slew_rate,
  input  logic [AW:0]                 ramplen,
  dac_setpt_ramp_engine_if.slave      tbl,
  input  logic                        ramp_run,
  input  logic                        ramp_abort,
  input  logic                        trig,
  output logic signed [DAC_WIDTH-1:0] dac_out,
  output logic                        dac_valid,
  output logic                        ramp_active,
  output logic                        ramp_done,
  output logic [AW-1:0]               ramp_idx
);

  localparam int W = DAC_WIDTH;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(RAMP_DEPTH);

  typedef enum logic [1:0] {
    MODE_SMOOTH = 2'd0,
    MODE_ONCE   = 2'd1,
    MODE_LOOP   = 2'd2,
    MODE_JUMP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_LOOP
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic trig_q;
  logic trig_rise;
  logic ramp_mode;
  logic playing;
  logic abort_req;
  logic start_req;
  logic ramp_tick;
  logic ramp_done_d;

  assign trig_rise = trig & ~trig_q;
  assign ramp_mode = (mode_e'(opmode) == MODE_ONCE) || (mode_e'(opmode) == MODE_LOOP);
  assign playing   = (state_q != ST_IDLE);

  // Leaving the ramp modes while playing counts as an abort.
  assign abort_req = playing & (ramp_abort | ~ramp_mode);

  // Abort in the same cycle suppresses a start.
  assign start_req = (ramp_run | trig_rise) & ~ramp_abort & ~playing & ramp_mode
                   & (ramplen != '0);

  // A tick on the abort cycle falls back to the idle behaviour of opmode.
  assign ramp_tick = tick & playing & ~abort_req;

  assign ramp_active = playing;

  // ---------------------------------------------------------------------------
  // Ramp table (simple dual-port, 1-cycle read)
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] mem [RAMP_DEPTH];
  logic signed [W-1:0] rd_data;
  logic [AW-1:0]       idx_q;

  // NOTE: the table and its read register carry no reset so they map onto
  // block RAM; contents survive a channel reset by design.
  always_ff @(posedge clk) begin
    if (tbl.ramp_wr_en) mem[tbl.ramp_wr_addr] <= tbl.ramp_wr_data;
    if (ramp_tick)      rd_data <= mem[idx_q];
  end

  // ---------------------------------------------------------------------------
  // Smooth / jump value, computed one bit wider so the difference never wraps
  // ---------------------------------------------------------------------------
  logic signed [W:0]   out_x;
  logic signed [W:0]   diff;
  logic [W:0]          mag;
  logic [W:0]          slew_x;
  logic signed [W:0]   moved;
  logic signed [W-1:0] smooth_val;
  logic signed [W-1:0] idle_val;

  assign out_x  = {dac_out[W-1], dac_out};
  assign diff   = {setpt[W-1], setpt} - out_x;
  assign mag    = diff[W] ? $unsigned(-diff) : $unsigned(diff);
  assign slew_x = {2'b00, slew_rate};
  assign moved  = diff[W] ? (out_x - $signed(slew_x)) : (out_x + $signed(slew_x));

  // moved lies between dac_out and setpt, so truncating back to W bits is exact.
  assign smooth_val = (mag <= slew_x) ? setpt : moved[W-1:0];

  always_comb begin
    // NOTE: every always_comb output is assigned a default first so no latch
    // is inferred on paths the case does not cover.
    idle_val = dac_out;
    case (mode_e'(opmode))
      MODE_JUMP:   idle_val = setpt;
      MODE_SMOOTH: idle_val = smooth_val;
      default:     idle_val = dac_out;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1: tick capture, table read issue, index advance
  // ---------------------------------------------------------------------------
  logic                p_valid;
  logic                p_ramp;
  logic                p_last;
  logic [AW-1:0]       p_idx;
  logic signed [W-1:0] p_val;
  logic [AW:0]         len_q;
  logic                at_last;

  assign at_last = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q  <= 1'b0;
      p_valid <= 1'b0;
      p_ramp  <= 1'b0;
      p_last  <= 1'b0;
      p_idx   <= '0;
      p_val   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      trig_q  <= trig;
      p_valid <= tick;
      p_ramp  <= ramp_tick;
      p_last  <= at_last;
      p_idx   <= idx_q;
      p_val   <= idle_val;
      if (start_req) begin
        idx_q <= '0;
        len_q <= (ramplen > DEPTH_L) ? DEPTH_L : ramplen;
      end else if (ramp_tick) begin
        idx_q <= at_last ? '0 : idx_q + AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_out   <= '0;
      dac_valid <= 1'b0;
      ramp_done <= 1'b0;
      ramp_idx  <= '0;
    end else begin
      dac_valid <= p_valid;
      ramp_done <= ramp_done_d;
      if (p_valid) dac_out <= p_ramp ? rd_data : p_val;
      if (p_valid && p_ramp) ramp_idx <= p_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ramp_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) state_d = (mode_e'(opmode) == MODE_ONCE) ? ST_RUN : ST_LOOP;
      end
      ST_RUN: begin
        if (abort_req) begin
          state_d = ST_IDLE;
        end else if (p_valid && p_ramp && p_last) begin
          // Finish on the same edge that presents the last entry.
          state_d     = ST_IDLE;
          ramp_done_d = 1'b1;
        end
      end
      ST_LOOP: begin
        if (abort_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_setpt_ramp_engine.sv
// -----------------------------------------------------------------------------
// tb_dac_setpt_ramp_engine
// Directed bench for dac_setpt_ramp_engine: jump, smooth slewing, signed
// extremes, one-shot and looping ramps, start/abort corner cases and reset.
// -----------------------------------------------------------------------------
module tb_dac_setpt_ramp_engine;
  localparam int W  = 20;
  localparam int D  = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [1:0]    opmode;
  logic [W-1:0]  setpt;
  logic [W-2:0]  slew_rate;
  logic [AW:0]   ramplen;
  logic          ramp_run;
  logic          ramp_abort;
  logic          trig;
  logic [W-1:0]  dac_out;
  logic          dac_valid;
  logic          ramp_active;
  logic          ramp_done;
  logic [AW-1:0] ramp_idx;

  int total = 0;
  int bad   = 0;

  dac_setpt_ramp_engine_if #(.DAC_WIDTH(W), .AW(AW)) tbl_if ();

  dac_setpt_ramp_engine #(.DAC_WIDTH(W), .RAMP_DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .opmode      (opmode),
    .setpt       (setpt),
    .slew_rate   (slew_rate),
    .ramplen     (ramplen),
    .tbl         (tbl_if),
    .ramp_run    (ramp_run),
    .ramp_abort  (ramp_abort),
    .trig        (trig),
    .dac_out     (dac_out),
    .dac_valid   (dac_valid),
    .ramp_active (ramp_active),
    .ramp_done   (ramp_done),
    .ramp_idx    (ramp_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Tick (optionally with ramp_run in the same cycle); output must appear
  // exactly two clocks later.
  task automatic tick_exp(input string tag, input logic [31:0] exp,
                          input bit exp_done, input bit with_run);
    @(posedge clk); #1;
    tick = 1'b1; ramp_run = with_run;
    @(posedge clk); #1;
    tick = 1'b0; ramp_run = 1'b0;
    check({tag, "_vld_early"}, 32'(dac_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_vld"},  32'(dac_valid), 32'd1);
    check({tag, "_out"},  32'(dac_out),   exp);
    check({tag, "_done"}, 32'(ramp_done), 32'(exp_done));
  endtask

  task automatic pulse_run();
    @(posedge clk); #1 ramp_run = 1'b1;
    @(posedge clk); #1 ramp_run = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"},    32'(dac_out),     32'd0);
    check({tag, "_vld"},    32'(dac_valid),   32'd0);
    check({tag, "_active"}, 32'(ramp_active), 32'd0);
    check({tag, "_done"},   32'(ramp_done),   32'd0);
    check({tag, "_idx"},    32'(ramp_idx),    32'd0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; opmode = 2'd3; setpt = '0; slew_rate = '0;
    ramplen = '0; ramp_run = 1'b0; ramp_abort = 1'b0; trig = 1'b0;
    tbl_if.ramp_wr_en = 1'b0; tbl_if.ramp_wr_addr = '0; tbl_if.ramp_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("rst");

    // Jump
    opmode = 2'd3; setpt = 20'h01234;
    tick_exp("jump", 32'h01234, 1'b0, 1'b0);

    // Smooth from 0 toward 100 at 30/tick, then slew 0 holds
    setpt = '0;
    tick_exp("jump0", 32'd0, 1'b0, 1'b0);
    opmode = 2'd0; setpt = 20'd100; slew_rate = 19'd30;
    tick_exp("sm1", 32'd30,  1'b0, 1'b0);
    tick_exp("sm2", 32'd60,  1'b0, 1'b0);
    tick_exp("sm3", 32'd90,  1'b0, 1'b0);
    tick_exp("sm4", 32'd100, 1'b0, 1'b0);
    tick_exp("sm5", 32'd100, 1'b0, 1'b0);
    setpt = 20'd50; slew_rate = '0;
    tick_exp("sm_slew0", 32'd100, 1'b0, 1'b0);

    // Full-scale swing: +524287 -> -524288 with slew 524287:
    // 524287-524287=0, then 0-524287=-524287 (0x80001), then |diff|=1 -> setpt.
    opmode = 2'd3; setpt = 20'h7FFFF;
    tick_exp("max", 32'h7FFFF, 1'b0, 1'b0);
    opmode = 2'd0; setpt = 20'h80000; slew_rate = 19'h7FFFF;
    tick_exp("ovf1", 32'h00000, 1'b0, 1'b0);
    tick_exp("ovf2", 32'h80001, 1'b0, 1'b0);
    tick_exp("ovf3", 32'h80000, 1'b0, 1'b0);

    // Load table[i] = i + 10
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk); #1;
      tbl_if.ramp_wr_en = 1'b1; tbl_if.ramp_wr_addr = AW'(i); tbl_if.ramp_wr_data = W'(i + 10);
    end
    @(posedge clk); #1 tbl_if.ramp_wr_en = 1'b0;

    // One-shot ramp; start coincides with a tick, which only holds dac_out
    opmode = 2'd1; ramplen = 11'd10;
    tick_exp("sim_start", 32'h80000, 1'b0, 1'b1);
    check("once_active", 32'(ramp_active), 32'd1);
    ramplen = 11'd3;   // ignored mid-play
    for (int k = 0; k < 12; k++) begin
      tick_exp($sformatf("once%0d", k), (k < 10) ? 32'(10 + k) : 32'd19,
               (k == 9), 1'b0);
      if (k == 9) begin
        check("once_active_fall", 32'(ramp_active), 32'd0);
        check("once_idx", 32'(ramp_idx), 32'd9);
      end
    end

    // Looping ramp from trig edge; re-trigger and ramp_run mid-play ignored
    opmode = 2'd2; ramplen = 11'd10;
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1;
    check("loop_active", 32'(ramp_active), 32'd1);
    for (int k = 0; k < 25; k++) begin
      if (k == 5) begin
        @(posedge clk); #1 trig = 1'b0;
        @(posedge clk); #1 trig = 1'b1; ramp_run = 1'b1;
        @(posedge clk); #1 ramp_run = 1'b0;
      end
      tick_exp($sformatf("loop%0d", k), 32'(10 + (k % 10)), 1'b0, 1'b0);
    end
    trig = 1'b0;
    @(posedge clk); #1 ramp_abort = 1'b1;
    @(posedge clk); #1 ramp_abort = 1'b0;
    check("abort_active", 32'(ramp_active), 32'd0);
    check("abort_out", 32'(dac_out), 32'd14);
    check("abort_idx", 32'(ramp_idx), 32'd4);
    tick_exp("abort_hold", 32'd14, 1'b0, 1'b0);

    // opmode leaving the ramp modes aborts
    opmode = 2'd1;
    pulse_run();
    tick_exp("om0", 32'd10, 1'b0, 1'b0);
    tick_exp("om1", 32'd11, 1'b0, 1'b0);
    tick_exp("om2", 32'd12, 1'b0, 1'b0);
    setpt = 20'h00777;
    @(posedge clk); #1 opmode = 2'd3;
    @(posedge clk); #1;
    check("om_abort_active", 32'(ramp_active), 32'd0);
    check("om_abort_out", 32'(dac_out), 32'd12);
    tick_exp("om_jump", 32'h00777, 1'b0, 1'b0);

    // Start with ramplen=0, and start together with abort: both ignored
    opmode = 2'd1; ramplen = '0;
    pulse_run();
    check("len0_active", 32'(ramp_active), 32'd0);
    ramplen = 11'd10;
    @(posedge clk); #1 ramp_run = 1'b1; ramp_abort = 1'b1;
    @(posedge clk); #1 ramp_run = 1'b0; ramp_abort = 1'b0;
    check("abort_start_active", 32'(ramp_active), 32'd0);

    // Reset mid-ramp; table survives
    pulse_run();
    check("rr_active", 32'(ramp_active), 32'd1);
    tick_exp("rr0", 32'd10, 1'b0, 1'b0);
    tick_exp("rr1", 32'd11, 1'b0, 1'b0);
    pulse_reset();
    check_reset_state("midrst");
    pulse_run();
    tick_exp("post0", 32'd10, 1'b0, 1'b0);
    tick_exp("post1", 32'd11, 1'b0, 1'b0);
    check("post_idx", 32'(ramp_idx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
